// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver state encoding and default frame geometry.
package usart_pkg;

    localparam int unsigned DefaultDataBits   = 8;
    localparam int unsigned DefaultOversample = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } usart_rx_state_t;

endpackage

// File: rtl/usart_sync.sv
// Two-flop synchroniser for a single asynchronous input, with selectable reset value.
module usart_sync #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/usart_rx.sv
// USART receiver: oversampled start-bit detection, centre sampling of 8N1 frames,
// valid/ack handoff with sticky overrun and a one-cycle framing-error pulse.
module usart_rx
    import usart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DefaultDataBits,
    parameter int unsigned OVERSAMPLE = DefaultOversample
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_clock,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 rx_overrun,
    output logic                 rx_frame_error
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

    logic sclk_sync, rx_sync, tick;
    logic sclk_prev_q, sclk_prev_d;

    usart_rx_state_t state_q, state_d;

    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d, tick_next;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 fe_q, fe_d;

    usart_sync #(.ResetVal(1'b1)) u_sync_sclk (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (serial_clock),
        .q_o   (sclk_sync)
    );

    usart_sync #(.ResetVal(1'b1)) u_sync_rx (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (rx_pin),
        .q_o   (rx_sync)
    );

    assign tick      = sclk_sync & ~sclk_prev_q;
    assign tick_next = (tick_cnt_q == FullLast) ? '0 : tick_cnt_q + 1'b1;

    always_comb begin
        sclk_prev_d = sclk_sync;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        fe_d        = 1'b0;

        // Ack first so a good stop bit in the same cycle reloads and re-asserts valid.
        if (rx_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (tick && !rx_sync) begin
                    tick_cnt_d = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tick_cnt_q == HalfLast) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_sync ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    tick_cnt_d = tick_next;
                    if (tick_cnt_q == FullLast) begin
                        shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            state_d = StStop;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    tick_cnt_d = tick_next;
                    if (tick_cnt_q == FullLast) begin
                        if (!rx_sync) begin
                            fe_d    = 1'b1;
                            state_d = StBreak;
                        end else begin
                            state_d = StIdle;
                            if (!valid_q || rx_ack) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end
                end
            end
            StBreak: begin
                if (tick && rx_sync) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_prev_q <= 1'b1;
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            fe_q        <= fe_d;
        end
    end

    assign rx_data        = data_q;
    assign rx_valid       = valid_q;
    assign rx_overrun     = overrun_q;
    assign rx_frame_error = fe_q;

endmodule

// File: tb/tb_usart_rx.sv
// Bench for usart_rx: frame-level reference model, per-cycle compare, directed and random frames.
module tb_usart_rx;

    logic       clock        = 1'b0;
    logic       reset        = 1'b1;
    logic       serial_clock = 1'b0;
    logic       rx_pin       = 1'b1;
    logic       rx_ack       = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_error;

    int checks = 0;
    int errors = 0;

    // Frame-level model state.
    logic [7:0] exp_data    = 8'h00;
    logic       exp_valid   = 1'b0;
    logic       exp_overrun = 1'b0;
    int         exp_fe      = 0;
    int         fe_seen     = 0;
    logic       fe_prev     = 1'b0;
    bit         chk_en      = 1'b0;

    usart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .serial_clock   (serial_clock),
        .rx_pin         (rx_pin),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ack         (rx_ack),
        .rx_overrun     (rx_overrun),
        .rx_frame_error (rx_frame_error)
    );

    always #5 clock = ~clock;

    // Oversampling clock: one rising edge every 4 system clocks.
    initial begin
        forever begin
            repeat (2) @(posedge clock);
            #1 serial_clock = ~serial_clock;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (rx_frame_error === 1'b1) begin
            fe_seen++;
            check("fe_pulse_width", {31'd0, fe_prev}, 32'd0);
        end
        fe_prev = rx_frame_error;
        if (chk_en) begin
            check("valid", {31'd0, rx_valid}, {31'd0, exp_valid});
            check("data", {24'd0, rx_data}, {24'd0, exp_data});
            check("overrun", {31'd0, rx_overrun}, {31'd0, exp_overrun});
            check("fe_count", fe_seen, exp_fe);
        end
    end

    task automatic bits_out(input logic v, input int n);
        rx_pin = v;
        repeat (n) @(posedge serial_clock);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop, input bit collide);
        if (!stop) begin
            exp_fe++;
        end else if (!exp_valid || collide) begin
            exp_data    = d;
            exp_valid   = 1'b1;
            exp_overrun = 1'b0;
        end else begin
            exp_overrun = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit collide);
        bits_out(1'b0, 16);
        for (int i = 0; i < 8; i++) bits_out(d[i], 16);
        chk_en = 1'b0;
        rx_pin = stop;
        repeat (8) @(posedge serial_clock);
        if (collide) begin
            // Ack lands on the cycle the stop-centre tick is seen after synchronisation.
            @(posedge clock);
            @(posedge clock);
            #1 rx_ack = 1'b1;
            @(posedge clock);
            #1 rx_ack = 1'b0;
        end
        repeat (8) @(posedge serial_clock);
        model_frame(d, stop, collide);
        chk_en = 1'b1;
    endtask

    task automatic do_ack();
        @(posedge clock);
        #1 rx_ack = 1'b1;
        @(posedge clock);
        #1 rx_ack = 1'b0;
        if (exp_valid) begin
            exp_valid   = 1'b0;
            exp_overrun = 1'b0;
        end
        @(posedge serial_clock);
    endtask

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check("rst_fe", {31'd0, rx_frame_error}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(posedge serial_clock);
        bits_out(1'b1, 20);

        // Single frame and ack.
        send_frame(8'hAA, 1'b1, 1'b0);
        check("aa_data", {24'd0, rx_data}, 32'hAA);
        check("aa_valid", {31'd0, rx_valid}, 32'd1);
        check("aa_overrun", {31'd0, rx_overrun}, 32'd0);
        check("aa_fe", fe_seen, 32'd0);
        do_ack();
        check("aa_ack_valid", {31'd0, rx_valid}, 32'd0);

        // Short low glitch must not start a frame.
        bits_out(1'b0, 3);
        bits_out(1'b1, 20);
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);

        // Low stop bit followed by a held-low break.
        send_frame(8'h55, 1'b0, 1'b0);
        bits_out(1'b0, 32);
        check("fe_count_lit", fe_seen, 32'd1);
        check("fe_valid", {31'd0, rx_valid}, 32'd0);
        bits_out(1'b1, 16);
        send_frame(8'h81, 1'b1, 1'b0);
        check("after_break_data", {24'd0, rx_data}, 32'h81);
        do_ack();

        // Overrun: second byte dropped.
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        check("ovr_data", {24'd0, rx_data}, 32'h12);
        check("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        do_ack();
        check("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
        check("ovr_ack_flag", {31'd0, rx_overrun}, 32'd0);

        // Ack coinciding with a good stop bit.
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b1);
        check("coll_data", {24'd0, rx_data}, 32'h34);
        check("coll_valid", {31'd0, rx_valid}, 32'd1);
        check("coll_overrun", {31'd0, rx_overrun}, 32'd0);
        do_ack();

        // Reset mid-frame while a byte is pending.
        send_frame(8'h5A, 1'b1, 1'b0);
        chk_en = 1'b0;
        bits_out(1'b0, 16);
        bits_out(1'b1, 40);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_overrun", {31'd0, rx_overrun}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        exp_data    = 8'h00;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
        @(posedge serial_clock);
        bits_out(1'b1, 20);
        chk_en = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b0);
        check("post_rst_data", {24'd0, rx_data}, 32'h3C);
        do_ack();

        // Randomised frames, gaps, stop errors and acks.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic       stop;
            int         gap;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(d, stop, 1'b0);
            if (!stop) begin
                bits_out(1'b0, $urandom_range(0, 20));
                gap = $urandom_range(1, 6);
            end else begin
                gap = $urandom_range(0, 6);
            end
            if (gap > 0) bits_out(1'b1, gap);
            if ($urandom_range(0, 2) == 0) do_ack();
        end
        bits_out(1'b1, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
